// File: rtl/hub75_pkg.sv
// hub75_pkg: shared state encoding, pixel-word field layout and defaults for the HUB-75 row path
package hub75_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, SHIFT, BLANK, LATCH, DISPLAY, GUARD, DONE} state_t;
  localparam int DEFAULT_WIDTH = 64;
  localparam int DEFAULT_COLOR_WIDTH = 8;
  localparam int ON_TIME_WIDTH = 16;
  localparam int UPPER_B = 0;
  localparam int UPPER_G = 1;
  localparam int UPPER_R = 2;
  localparam int LOWER_B = 3;
  localparam int LOWER_G = 4;
  localparam int LOWER_R = 5;
  function automatic int field_lsb(int field, int color_width);
    return field * color_width;
  endfunction
endpackage

// File: rtl/hub75_on_timer.sv
// hub75_on_timer: loadable down-counter timing BCM on-time and guard intervals
//   clock, reset (async active-low), load/value start a count, expired flags its final cycle
module hub75_on_timer
  import hub75_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     load,
  input  logic [ON_TIME_WIDTH-1:0] value,
  output logic                     expired
);
  logic [ON_TIME_WIDTH-1:0] count;
  always_ff @(posedge clock or negedge reset)
    if (!reset) count <= '0;
    else if (load) count <= value;
    else if (count != '0) count <= count - 1'b1;
  // A count of N loaded on entry expires during the Nth cycle of the timed state.
  assign expired = count <= ON_TIME_WIDTH'(1);
endmodule

// File: rtl/hub75_row_shifter.sv
// hub75_row_shifter: serialises one line-buffer row pair onto HUB-75 as BCM bit planes, MSB plane first
//   clock, reset (async active-low); start/y/bank request a row, done/busy report progress
//   read_address/read_data access the line buffer ({bank,x}, 1-cycle read latency)
//   r1,g1,b1,r2,g2,b2, row_addr, shift_clk, lat, oe_n drive the connector
//   HUB75_GHOST_GUARD_EN: stretches BLANK and adds a GUARD blank after DISPLAY, both GUARD_CYCLES long
module hub75_row_shifter
  import hub75_pkg::*;
#(
  parameter int WIDTH        = DEFAULT_WIDTH,
  parameter int COLOR_WIDTH  = DEFAULT_COLOR_WIDTH,
  parameter int BIT_DEPTH    = 8,
  parameter int BASE_ON_TIME = 1,
  parameter int ROW_WIDTH    = 5,
  parameter int GUARD_CYCLES = 4
)(
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [ROW_WIDTH-1:0]       y,
  input  logic                       bank,
  output logic                       done,
  output logic                       busy,
  output logic [$clog2(WIDTH):0]     read_address,
  input  logic [6*COLOR_WIDTH-1:0]   read_data,
  output logic                       r1,
  output logic                       g1,
  output logic                       b1,
  output logic                       r2,
  output logic                       g2,
  output logic                       b2,
  output logic [ROW_WIDTH-1:0]       row_addr,
  output logic                       shift_clk,
  output logic                       lat,
  output logic                       oe_n
);
  localparam int XW = $clog2(WIDTH);
  localparam int PW = $clog2(BIT_DEPTH + 1);
  localparam int LSB = COLOR_WIDTH - BIT_DEPTH;
  if (BIT_DEPTH < 1 || BIT_DEPTH > COLOR_WIDTH || BASE_ON_TIME < 1 || WIDTH < 2 || ROW_WIDTH < 1 ||
      GUARD_CYCLES < 1 || (longint'(BASE_ON_TIME) << (BIT_DEPTH - 1)) >= (longint'(1) << ON_TIME_WIDTH)) begin : g_bad_params
    $error("hub75_row_shifter: parameter out of range");
  end
  state_t state, state_d;
  logic [PW-1:0] plane;
  logic [XW-1:0] x, ra_x;
  logic phase, bank_q, last_col, load, expired;
  logic [ROW_WIDTH-1:0] y_q;
  logic [5:0] plane_bits, colour, colour_q;
  logic [ON_TIME_WIDTH-1:0] on_time, timer_value;
  assign last_col = x == XW'(WIDTH - 1);
  assign on_time = ON_TIME_WIDTH'(BASE_ON_TIME) << plane;
`ifdef HUB75_GHOST_GUARD_EN
  assign timer_value = state == LATCH ? on_time : ON_TIME_WIDTH'(GUARD_CYCLES);
`else
  assign timer_value = on_time;
`endif
  hub75_on_timer u_timer (
    .clock   (clock),
    .reset   (reset),
    .load    (load),
    .value   (timer_value),
    .expired (expired)
  );
  always_comb begin
    state_d = state;
    load = 1'b0;
    case (state)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   state_d = SHIFT;
      SHIFT:   if (phase && last_col) begin
`ifdef HUB75_GHOST_GUARD_EN
        load = 1'b1;
`endif
        state_d = BLANK;
      end
`ifdef HUB75_GHOST_GUARD_EN
      BLANK:   if (expired) state_d = LATCH;
`else
      BLANK:   state_d = LATCH;
`endif
      LATCH:   begin
        load = 1'b1;
        state_d = DISPLAY;
      end
`ifdef HUB75_GHOST_GUARD_EN
      DISPLAY: if (expired) begin
        load = 1'b1;
        state_d = GUARD;
      end
      GUARD:   if (expired) state_d = plane == '0 ? DONE : FETCH;
`else
      DISPLAY: if (expired) state_d = plane == '0 ? DONE : FETCH;
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      plane <= PW'(BIT_DEPTH - 1);
      x <= '0;
      ra_x <= '0;
      phase <= 1'b0;
      bank_q <= 1'b0;
      y_q <= '0;
      row_addr <= '0;
      colour_q <= '0;
    end else begin
      state <= state_d;
      if (state == IDLE && start) begin
        y_q <= y;
        bank_q <= bank;
        plane <= PW'(BIT_DEPTH - 1);
      end else if (state_d == FETCH) plane <= plane - 1'b1;
      // Address runs one column ahead of the serialised column to hide the read latency.
      if (state_d == FETCH) ra_x <= '0;
      else if (state == SHIFT && !phase && !last_col) ra_x <= x + 1'b1;
      if (state == SHIFT) begin
        phase <= ~phase;
        if (phase) x <= last_col ? '0 : x + 1'b1;
      end
      if (state == SHIFT && !phase) colour_q <= colour;
      if (state == BLANK) row_addr <= y_q;
    end
  for (genvar i = 0; i < 6; i++) begin : g_bit
    assign plane_bits[i] = 1'(read_data[field_lsb(i, COLOR_WIDTH) +: COLOR_WIDTH] >> (LSB + int'(plane)));
  end
  // Phase 0 passes read data straight through so it is stable a full cycle before shift_clk rises.
  assign colour = state == SHIFT && !phase ?
    {plane_bits[UPPER_R], plane_bits[UPPER_G], plane_bits[UPPER_B],
     plane_bits[LOWER_R], plane_bits[LOWER_G], plane_bits[LOWER_B]} : colour_q;
  assign {r1, g1, b1, r2, g2, b2} = colour;
  assign read_address = {bank_q, ra_x};
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign lat = state == LATCH;
  assign oe_n = state != DISPLAY;
  assign shift_clk = state == SHIFT && phase;
endmodule

// File: tb/tb_hub75_row_shifter.sv
// tb_hub75_row_shifter: directed checks of the HUB-75 row shifter (default and BIT_DEPTH=1 instances)
module tb_hub75_row_shifter;
`ifdef HUB75_GHOST_GUARD_EN
  localparam int LAT = 1360;
  localparam int LAT1 = 143;
`else
  localparam int LAT = 1304;
  localparam int LAT1 = 136;
`endif
  logic clk = 1'b0;
  logic reset, start, start2, bank;
  logic [4:0] y;
  logic done, busy, r1, g1, b1, r2, g2, b2, shift_clk, lat, oe_n;
  logic done2, busy2, r12, g12, b12, r22, g22, b22, shift_clk2, lat2, oe_n2;
  logic [6:0] read_address, read_address2;
  logic [4:0] row_addr, row_addr2;
  logic [47:0] rd, rd2;
  logic [47:0] mem [128];
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int mode = 0;
  int bank_exp = 1;
  int row_exp = 5;
  logic shift_p = 1'b0, oe_p = 1'b1, lat_p = 1'b0, busy_p = 1'b0, lat2_p = 1'b0;
  logic [4:0] row_p = '0;
  int rises_run = 0, r1_run = 0, oe_run = 0, pl = 7;
  int lat_total = 0, addr_bad = 0, col_bad = 0, row_bad = 0, brise = 0, oe2_low = 0, lat2_total = 0;
  int rq[$], r1q[$], oeq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    rd <= mem[read_address];
    rd2 <= mem[read_address2];
  end

  hub75_row_shifter u_dut (
    .clock(clk), .reset(reset), .start(start), .y(y), .bank(bank), .done(done), .busy(busy),
    .read_address(read_address), .read_data(rd), .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2),
    .row_addr(row_addr), .shift_clk(shift_clk), .lat(lat), .oe_n(oe_n)
  );
  hub75_row_shifter #(.BIT_DEPTH(1), .BASE_ON_TIME(4)) u_bd1 (
    .clock(clk), .reset(reset), .start(start2), .y(y), .bank(bank), .done(done2), .busy(busy2),
    .read_address(read_address2), .read_data(rd2), .r1(r12), .g1(g12), .b1(b12), .r2(r22), .g2(g22), .b2(b22),
    .row_addr(row_addr2), .shift_clk(shift_clk2), .lat(lat2), .oe_n(oe_n2)
  );

  // Passive observer: per-plane shift-edge counts, on-time runs and column/address expectations.
  always @(negedge clk) begin
    shift_p <= shift_clk;
    oe_p <= oe_n;
    lat_p <= lat;
    row_p <= row_addr;
    busy_p <= busy;
    lat2_p <= lat2;
    if (busy && !busy_p) brise <= cyc;
    if (!oe_n2) oe2_low <= oe2_low + 1;
    if (lat2 && !lat2_p) lat2_total <= lat2_total + 1;
    if (!oe_n) oe_run <= oe_run + 1;
    else if (!oe_p) begin
      oeq.push_back(oe_run);
      oe_run <= 0;
    end
    if (!oe_n && (row_addr !== 5'(row_exp) || (!oe_p && row_addr !== row_p))) row_bad <= row_bad + 1;
    if (shift_clk && !shift_p) begin
      rises_run <= rises_run + 1;
      if (r1) r1_run <= r1_run + 1;
      if (mode != 0 && 32'(read_address) !== (bank_exp != 0 ? 64 : 0) + (rises_run < 63 ? rises_run + 1 : 63))
        addr_bad <= addr_bad + 1;
      if (mode != 0 && {r1, g1, b1, r2, g2, b2} !==
          (mode == 1 ? {6{rises_run[pl]}} : (pl == 7 ? 6'b100000 : 6'b000000)))
        col_bad <= col_bad + 1;
    end
    if (lat && !lat_p) begin
      lat_total <= lat_total + 1;
      rq.push_back(rises_run);
      r1q.push_back(r1_run);
      rises_run <= 0;
      r1_run <= 0;
      pl <= pl == 0 ? 7 : pl - 1;
    end
    if (!reset) begin
      rises_run <= 0;
      r1_run <= 0;
      pl <= 7;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int d);
    for (int i = 0; i < 3000 && done !== 1'b1; i++) step();
    d = done === 1'b1 ? cyc : -1;
  endtask

  initial begin
    int k, d, d1, d2, ri, oi, lt, ab, cb, rb, o2, l2;
    reset = 1'b0;
    start = 1'b0;
    start2 = 1'b0;
    y = 5'd5;
    bank = 1'b1;
    for (int i = 0; i < 64; i++) begin
      mem[i] = '1;
      mem[64 + i] = {6{8'(i)}};
    end
    repeat (3) step();
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", read_address, 0);
    chk("rst_colour", {r1, g1, b1, r2, g2, b2}, 0);
    chk("rst_row", row_addr, 0);
    chk("rst_sclk", shift_clk, 0);
    chk("rst_lat", lat, 0);
    chk("rst_oe_n", oe_n, 1);
    chk("rst_busy2", busy2, 0);
    reset = 1'b1;
    step();

    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 1000 && oe_n !== 1'b0; i++) step();
    chk("mid_reached_display", oe_n, 0);
    reset = 1'b0;
    #1;
    chk("mid_oe_n", oe_n, 1);
    chk("mid_lat", lat, 0);
    chk("mid_busy", busy, 0);
    chk("mid_sclk", shift_clk, 0);
    step();
    step();
    reset = 1'b1;
    step();

    mode = 1;
    ri = rq.size();
    oi = oeq.size();
    lt = lat_total;
    ab = addr_bad;
    cb = col_bad;
    rb = row_bad;
    start = 1'b1;
    k = cyc;
    step();
    start = 1'b0;
    chk("a_fetch_busy", busy, 1);
    chk("a_fetch_addr", read_address, 64);
    wait_done(d);
    chk("a_done_latency", d - k, LAT);
    step();
    chk("a_idle", busy, 0);
    chk("a_lat_pulses", lat_total - lt, 8);
    for (int i = 0; i < 8; i++) chk($sformatf("a_rises_p%0d", 7 - i), rq.size() > ri + i ? rq[ri + i] : -1, 64);
    for (int i = 0; i < 8; i++) chk($sformatf("a_on_p%0d", 7 - i), oeq.size() > oi + i ? oeq[oi + i] : -1, 128 >> i);
    chk("a_addr_seq", addr_bad - ab, 0);
    chk("a_colour", col_bad - cb, 0);
    chk("a_row_stable", row_bad - rb, 0);
    chk("a_row_addr", row_addr, 5);

    for (int i = 0; i < 64; i++) mem[64 + i] = 48'h0000_0080_0000;
    mode = 2;
    ri = rq.size();
    oi = oeq.size();
    cb = col_bad;
    start = 1'b1;
    k = cyc;
    step();
    start = 1'b0;
    wait_done(d);
    chk("b_done_latency", d - k, LAT);
    step();
    for (int i = 0; i < 8; i++) chk($sformatf("b_r1_p%0d", 7 - i), r1q.size() > ri + i ? r1q[ri + i] : -1, i == 0 ? 64 : 0);
    chk("b_colour", col_bad - cb, 0);
    chk("b_on_p7", oeq.size() > oi ? oeq[oi] : -1, 128);
    chk("b_on_p0", oeq.size() > oi + 7 ? oeq[oi + 7] : -1, 1);

    mode = 0;
    start = 1'b1;
    k = cyc;
    wait_done(d1);
    chk("c_done1_latency", d1 - k, LAT);
    step();
    wait_done(d2);
    start = 1'b0;
    chk("c_gap_to_fetch", brise - d1, 2);
    chk("c_row_period", d2 - d1, LAT + 1);
    step();
    step();
    chk("c_idle", busy, 0);

    o2 = oe2_low;
    l2 = lat2_total;
    start2 = 1'b1;
    k = cyc;
    step();
    start2 = 1'b0;
    for (int i = 0; i < 500 && done2 !== 1'b1; i++) step();
    d = done2 === 1'b1 ? cyc : -1;
    chk("d_done_latency", d - k, LAT1);
    step();
    chk("d_on_cycles", oe2_low - o2, 4);
    chk("d_lat_pulses", lat2_total - l2, 1);
    chk("d_idle", busy2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
